// File: rtl/corr_event_collector_pkg.sv
// corr_event_collector_pkg: shared register map, default sizes and field widths
package corr_event_collector_pkg;
  localparam logic [15:0] ADDR_SEEN = 16'h0108;
  localparam logic [15:0] ADDR_POP = 16'h010C;
  localparam logic [15:0] ADDR_IRQ_EN = 16'h0110;
  localparam logic [15:0] ADDR_STATUS = 16'h0114;
  localparam int NUM_CH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int CH_ID_W = 4;
  localparam int CNT_W = 5;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous FIFO with simultaneous push/pop and occupancy count
module event_fifo #(
  parameter int W = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o = mem_q[rp_q];
  assign do_push = push_i & ~full_o;
  assign do_pop = pop_i & ~empty_o;
  // pointers and count; a blocked push or pop leaves its side untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset, the count guards what is visible
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end
endmodule

// File: rtl/corr_event_collector.sv
// corr_event_collector: latches correlator channel rises and queues them as events on a register bus
module corr_event_collector
  import corr_event_collector_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       Wdata,
  input  logic              write,
  input  logic              read,
  output logic [31:0]       Rdata,
  input  logic [NUM_CH-1:0] cseen,
  output logic              irq
);
  localparam int IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [NUM_CH-1:0] cseen_q, seen_q, seen_d, pend_q, pend_d, rise, grant;
  logic ovf_q, ovf_d, en_q, en_d, irq_q, rd_q;
  logic [15:0] a, raddr_q;
  logic first, seen_clr, pop_req, push, full, empty;
  logic [IDW-1:0] pick_id, head_id;
  logic [CW-1:0] cnt;
  logic [CNT_W-1:0] cnt_f;
  logic [CH_ID_W-1:0] pop_id;
  logic unused_bits;
  assign a = addr[15:0];
  assign first = read & ~(rd_q & (raddr_q == a));
  assign seen_clr = first & (a == ADDR_SEEN);
  assign pop_req = first & (a == ADDR_POP);
  assign rise = cseen & ~cseen_q;
  assign push = |pend_q & ~full;
  assign grant = push ? NUM_CH'(1) << pick_id : '0;
  assign seen_d = (seen_clr ? '0 : seen_q) | rise;
  assign pend_d = (pend_q & ~grant) | (rise & ~pend_q);
  assign ovf_d = (ovf_q & ~(write & (a == ADDR_STATUS) & Wdata[8])) | |(rise & pend_q);
  assign en_d = (write & (a == ADDR_IRQ_EN)) ? Wdata[0] : en_q;
  assign cnt_f = CNT_W'(cnt);
  assign pop_id = empty ? '0 : CH_ID_W'(head_id);
  assign irq = irq_q;
  assign unused_bits = ^{addr[31:16], Wdata[31:9], Wdata[7:1]};
  // lowest-index pending channel wins the single enqueue slot
  always_comb begin
    pick_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (pend_q[i]) pick_id = IDW'(i);
  end
  // read mux; POP shows the current head, never the entry being written this cycle
  always_comb begin
    Rdata = !read ? '0 :
            a == ADDR_SEEN   ? 32'(seen_q) :
            a == ADDR_POP    ? {~empty, ovf_q, 9'd0, cnt_f, 12'd0, pop_id} :
            a == ADDR_IRQ_EN ? {31'd0, en_q} :
            a == ADDR_STATUS ? {23'd0, ovf_q, 3'd0, cnt_f} : '0;
  end
  // channel tracking, control registers and access-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      cseen_q <= '0;
      seen_q <= '0;
      pend_q <= '0;
      ovf_q <= 1'b0;
      en_q <= 1'b0;
      irq_q <= 1'b0;
      rd_q <= 1'b0;
      raddr_q <= '0;
    end else begin
      cseen_q <= cseen;
      seen_q <= seen_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
      en_q <= en_d;
      irq_q <= en_q & ((cnt != '0) | ovf_q);
      rd_q <= read;
      raddr_q <= a;
    end
  end
  event_fifo #(.W(IDW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop_req),
    .din_i   (pick_id),
    .dout_o  (head_id),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );
endmodule

// File: tb/tb_corr_event_collector.sv
// tb_corr_event_collector: scoreboard bench for the correlator event collector
module tb_corr_event_collector;
  import corr_event_collector_pkg::*;
  logic clk = 1'b0, rst = 1'b1, write = 1'b0, read = 1'b0, irq;
  logic [31:0] addr = '0, Wdata = '0, Rdata;
  logic [15:0] cseen = '0;
  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_q[$];

  corr_event_collector dut (
    .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write),
    .read(read), .Rdata(Rdata), .cseen(cseen), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d);
    addr = {16'h0, a};
    read = 1'b1;
    #2;
    d = Rdata;
    tick();
    read = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    addr = {16'h0, a};
    Wdata = d;
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  function automatic logic [31:0] pw(input logic v, input logic [4:0] c, input logic [3:0] id);
    return {v, 1'b0, 9'd0, c, 12'd0, id};
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    addr = {16'h0, ADDR_STATUS};
    #1;
    n_cmp++; if (Rdata !== 32'h0) begin n_err++; $display("FAIL reset_noread got=%h exp=%h", Rdata, 32'h0); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", irq); end
    do_read(ADDR_STATUS, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0); end
    do_read(ADDR_SEEN, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_seen got=%h exp=%h", d, 32'h0); end
    do_read(ADDR_POP, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_pop got=%h exp=%h", d, 32'h0); end
    do_read(ADDR_IRQ_EN, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_irqen got=%h exp=%h", d, 32'h0); end
    do_write(ADDR_SEEN, 32'hFFFF);
    do_read(ADDR_SEEN, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL ro_write_seen got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_single();
    logic [31:0] d, e;
    cseen[5] = 1'b1;
    exp_q.push_back(pw(1'b1, 5'd1, 4'd5));
    exp_q.push_back(32'h0);
    tick();
    addr = {16'h0, ADDR_POP};
    read = 1'b1;
    #1;
    n_cmp++; if (Rdata !== 32'h0) begin n_err++; $display("FAIL pop_too_early got=%h exp=%h", Rdata, 32'h0); end
    addr = {16'h0, ADDR_SEEN};
    #1;
    n_cmp++; if (Rdata !== 32'h20) begin n_err++; $display("FAIL seen_single got=%h exp=%h", Rdata, 32'h20); end
    tick();
    read = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      do_read(ADDR_POP, d);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL single_pop%0d got=%h exp=%h", i, d, e); end
    end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL single_irq_disabled got=%b exp=0", irq); end
    cseen = '0;
    tick();
  endtask

  task automatic test_multi();
    logic [31:0] d, e;
    cseen = 16'h0205;
    exp_q.push_back(pw(1'b1, 5'd3, 4'd0));
    exp_q.push_back(pw(1'b1, 5'd2, 4'd2));
    exp_q.push_back(pw(1'b1, 5'd1, 4'd9));
    exp_q.push_back(32'h0);
    tick(5);
    cseen = '0;
    tick();
    for (int i = 0; i < 4; i++) begin
      do_read(ADDR_POP, d);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL multi_pop%0d got=%h exp=%h", i, d, e); end
    end
  endtask

  task automatic test_full();
    logic [31:0] d, e;
    do_write(ADDR_IRQ_EN, 32'h1);
    for (int i = 0; i < 16; i++) begin
      cseen[i] = 1'b1;
      exp_q.push_back(pw(1'b1, (i == 0) ? 5'd16 : 5'(17 - i), 4'(i)));
      tick();
    end
    tick(4);
    cseen = '0;
    tick();
    cseen[0] = 1'b1;
    exp_q.push_back(pw(1'b1, 5'd1, 4'd0));
    exp_q.push_back(32'h0);
    tick(3);
    do_read(ADDR_STATUS, d);
    n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL full_status got=%h exp=%h", d, 32'h10); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL full_irq got=%b exp=1", irq); end
    for (int i = 0; i < 18; i++) begin
      do_read(ADDR_POP, d);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL full_pop%0d got=%h exp=%h", i, d, e); end
      if (i == 0) begin
        do_read(ADDR_STATUS, d);
        n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL full_refill got=%h exp=%h", d, 32'h10); end
      end
    end
    cseen = '0;
    tick(2);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL full_irq_drained got=%b exp=0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    do_write(ADDR_IRQ_EN, 32'h1);
    for (int i = 0; i < 16; i++) begin
      cseen[i] = 1'b1;
      exp_q.push_back(pw(1'b1, (i == 0) ? 5'd16 : 5'(17 - i), 4'(i)));
      tick();
    end
    tick(4);
    cseen = '0;
    tick(2);
    cseen[3] = 1'b1;
    exp_q.push_back(pw(1'b1, 5'd1, 4'd3));
    exp_q.push_back(32'h0);
    tick();
    cseen[3] = 1'b0;
    tick();
    cseen[3] = 1'b1;
    tick();
    cseen[3] = 1'b0;
    tick(2);
    do_read(ADDR_STATUS, d);
    n_cmp++; if (d !== 32'h110) begin n_err++; $display("FAIL ovf_status got=%h exp=%h", d, 32'h110); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ovf_irq got=%b exp=1", irq); end
    do_write(ADDR_STATUS, 32'h100);
    do_read(ADDR_STATUS, d);
    n_cmp++; if (d !== 32'h10) begin n_err++; $display("FAIL ovf_clear got=%h exp=%h", d, 32'h10); end
    for (int i = 0; i < 18; i++) begin
      do_read(ADDR_POP, d);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, d, e); end
    end
    tick(2);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ovf_irq_drained got=%b exp=0", irq); end
  endtask

  task automatic test_seen_hold();
    logic [31:0] d, e;
    do_read(ADDR_SEEN, d);
    cseen = 16'h0012;
    exp_q.push_back(pw(1'b1, 5'd3, 4'd1));
    exp_q.push_back(pw(1'b1, 5'd2, 4'd4));
    exp_q.push_back(pw(1'b1, 5'd1, 4'd7));
    exp_q.push_back(32'h0);
    tick(3);
    addr = {16'h0, ADDR_SEEN};
    read = 1'b1;
    cseen[7] = 1'b1;
    #1;
    n_cmp++; if (Rdata !== 32'h12) begin n_err++; $display("FAIL hold_c0 got=%h exp=%h", Rdata, 32'h12); end
    tick();
    n_cmp++; if (Rdata !== 32'h80) begin n_err++; $display("FAIL hold_c1 got=%h exp=%h", Rdata, 32'h80); end
    tick();
    n_cmp++; if (Rdata !== 32'h80) begin n_err++; $display("FAIL hold_c2 got=%h exp=%h", Rdata, 32'h80); end
    tick();
    read = 1'b0;
    tick();
    do_read(ADDR_SEEN, d);
    n_cmp++; if (d !== 32'h80) begin n_err++; $display("FAIL hold_after got=%h exp=%h", d, 32'h80); end
    do_read(ADDR_SEEN, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL hold_cleared got=%h exp=%h", d, 32'h0); end
    for (int i = 0; i < 4; i++) begin
      do_read(ADDR_POP, d);
      e = exp_q.pop_front();
      n_cmp++; if (d !== e) begin n_err++; $display("FAIL hold_pop%0d got=%h exp=%h", i, d, e); end
    end
    cseen = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    cseen = 16'h3C00;
    tick(6);
    cseen = '0;
    tick();
    do_read(ADDR_STATUS, d);
    n_cmp++; if (d !== 32'h4) begin n_err++; $display("FAIL mid_count got=%h exp=%h", d, 32'h4); end
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mid_irq_pre got=%b exp=1", irq); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq got=%b exp=0", irq); end
    do_read(ADDR_POP, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_pop got=%h exp=%h", d, 32'h0); end
    do_read(ADDR_SEEN, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_seen got=%h exp=%h", d, 32'h0); end
    do_read(ADDR_STATUS, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_status got=%h exp=%h", d, 32'h0); end
    do_read(ADDR_IRQ_EN, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_irqen got=%h exp=%h", d, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_full();
    test_overflow();
    test_seen_hold();
    test_reset_mid();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/corr_event_collector.md
CORR_EVENT_COLLECTOR -- requirements
Module: corr_event_collector

Interface
REQ-001 Parameter NUM_CH, default 16, number of correlator channels watched.
REQ-002 Parameter FIFO_DEPTH, default 16, event queue entries (power of two).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 addr  input  32  register bus address; only [15:0] decoded.
REQ-006 Wdata  input  32  register write data.
REQ-007 write  input  1  write strobe.
REQ-008 read  input  1  read strobe.
REQ-009 Rdata  output  32  read data.
REQ-010 cseen  input  NUM_CH  per-channel correlation-seen level, bit i from correlator channel i.
REQ-011 irq  output  1  event interrupt.

Function
REQ-012 Register map:
- 0x0108 SEEN (RO, read-clear): [NUM_CH-1:0] sticky seen bits.
- 0x010C POP (RO, read-pop): [31] valid, [30] overflow, [20:16] fifo count before pop, [3:0] channel id.
- 0x0110 IRQ_EN (RW): [0] enable.
- 0x0114 STATUS: [4:0] fifo count, [8] overflow; writing 1 to [8] clears overflow.
REQ-013 Rdata combinational: selected register when read=1 and addr matches, else 0; unmapped addresses return 0.
REQ-014 Read side effects (SEEN clear, POP dequeue) once per access: only on a cycle with read=1 where the previous cycle did not have read=1 at the same addr.
REQ-015 cseen registered to cseen_q; rise[i] = cseen[i] & ~cseen_q[i].
REQ-016 Edge k with rise[i]: seen[i] and pending[i] set at edge k.
REQ-017 Each edge: if pending nonzero and FIFO not full, lowest-index pending channel is enqueued and its pending bit cleared; at most one enqueue per cycle.
REQ-018 FIFO full: pending bits held, no loss, no overflow.
REQ-019 rise[i] while pending[i] already set: overflow set; no second entry.
REQ-020 Rise and SEEN-clear same cycle: affected bit stays set; other bits clear.
REQ-021 Enqueue and pop same cycle: both performed, count unchanged; pop of empty FIFO returns valid=0, no state change.
REQ-022 POP read data shows head entry of current cycle; entry enqueued same cycle is not visible.
REQ-023 Latency: rise at edge k -> SEEN readable after k; POP-valid and irq after edge k+1 at earliest.
REQ-024 irq registered: irq = IRQ_EN[0] & (count != 0 | overflow), updated each edge.
REQ-025 Write to read-only addresses has no effect; write and read never asserted together (bus contract).

Reset
REQ-026 rst=1 at an edge clears seen, pending, cseen_q, FIFO pointers/count, overflow, IRQ_EN, irq, read-tracking state; Rdata follows REQ-013 (0 without read).
REQ-027 Reset mid-operation discards queued events; cseen held high through reset is not a rise on the first post-reset cycle only if cseen_q captured it; cseen_q resets to 0, so level-high cseen after reset produces one rise.

Structure
REQ-028 Shared package holds register address constants (0x0108, 0x010C, 0x0110, 0x0114), NUM_CH and FIFO_DEPTH defaults, channel-id width.
REQ-029 One sub-module, event_fifo: synchronous FIFO, push/pop/full/empty/count, simultaneous push+pop supported, synchronous active-high reset.
REQ-030 Pending-bit priority encoder and register decode stay in corr_event_collector.

Verification
REQ-031 cseen[5] rises at edge 10 -> SEEN read returns 0x0020; POP after edge 11 returns valid=1, id=5, count=1; second POP returns valid=0.
REQ-032 cseen[2], cseen[9], cseen[0] rise same edge -> three POPs return ids 0, 2, 9 in order.
REQ-033 IRQ_EN=1, 17 distinct rises with no pops -> count 16, one channel held pending; after one POP it enqueues next edge; overflow stays 0.
REQ-034 cseen[3] pulses twice before its enqueue (FIFO full) -> overflow=1, irq=1; STATUS write 0x100 clears overflow.
REQ-035 SEEN read held 3 cycles while cseen[7] rises in first cycle -> bit 7 remains set, others cleared once.
REQ-036 rst asserted with 4 queued events -> POP returns valid=0, SEEN=0, irq=0 after reset edge.
